// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA timing receiver: measures sync timing, recovers pixel coordinates, reports lock
//
// Ports:
//   vga_clk, reset_n        pixel clock, asynchronous active-low reset
//   HS, VS, blank_n         incoming sync / blanking from the timing source
//   pixel_x/y, pixel_valid  coordinates of the visible pixel seen one cycle earlier
//   frame_start             one-cycle pulse after each VS rising edge
//   h_total/h_sync/h_active last measured line period, HS-high and blank_n-high cycles
//   v_total/v_sync/v_active last measured frame lines, VS-high lines, lines with visible pixels
//   locked                  timing has been stable for LOCK_FRAMES consecutive frames
// Optional feature (macro VGA_SYNC_DECODER_ERRCNT_EN):
//   err_count               saturating count of lock losses
//   err_clear               synchronous clear of err_count (wins over an increment)
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 11
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             HS,
  input  logic             VS,
  input  logic             blank_n,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_valid,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync,
  output logic [CNT_W-1:0] v_active,
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  output logic [15:0]      err_count,
  input  logic             err_clear,
`endif
  output logic             locked
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_n;
  logic [3:0]       match_cnt, match_n;
  logic             load_ref;
  logic             hs_q, vs_q, bl_q;
  logic             hs_rise, vs_rise, timeout;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] hs_acc, bl_acc, vs_acc, va_acc;
  logic             line_act;   // current line has shown blank_n high before this cycle
  logic             seen;       // a VS edge has been seen since reset
  logic [CNT_W-1:0] row, row_n; // visible-row index of the current line
  logic             pix_ok, px_first;
  logic [CNT_W-1:0] ht_n, hsy_n, ha_n, vt_n, vsy_n, va_n;
  logic [6*CNT_W-1:0] meas_n, ref_meas;

  assign hs_rise = HS & ~hs_q;
  assign vs_rise = VS & ~vs_q;
  assign timeout = (h_cnt == MAX) | (v_cnt == MAX);

  // Values the measurement registers take this cycle; the FSM compares these
  // so a coincident line end is already included at the frame boundary.
  assign ht_n  = hs_rise ? sat_inc(h_cnt) : h_total;
  assign hsy_n = hs_rise ? hs_acc : h_sync;
  assign ha_n  = (hs_rise && bl_acc != '0) ? bl_acc : h_active;
  assign vt_n  = vs_rise ? sat_inc(v_cnt) : v_total;
  assign vsy_n = vs_rise ? vs_acc : v_sync;
  assign va_n  = vs_rise ? ((hs_rise & line_act) ? sat_inc(va_acc) : va_acc) : v_active;
  assign meas_n = {ht_n, hsy_n, ha_n, vt_n, vsy_n, va_n};

  // A coincident hs_rise closes the last line of the old frame, so it never
  // advances the row of the new frame.
  assign row_n    = vs_rise ? '0 : ((hs_rise & line_act) ? sat_inc(row) : row);
  assign pix_ok   = blank_n & (seen | vs_rise);
  assign px_first = hs_rise | ~line_act;
  assign pixel_valid = bl_q & seen;

  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    load_ref = 1'b0;
    if (timeout) begin
      state_n = SEARCH;
      match_n = '0;
    end else if (vs_rise) begin
      case (state)
        SEARCH:  state_n = MEASURE;
        MEASURE: begin
          load_ref = 1'b1;
          match_n  = '0;
          state_n  = VERIFY;
        end
        VERIFY: begin
          if (meas_n == ref_meas) begin
            match_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 >= 4'(LOCK_FRAMES)) state_n = LOCKED;
          end else begin
            load_ref = 1'b1;
            match_n  = '0;
          end
        end
        default: begin
          if (meas_n != ref_meas) begin
            load_ref = 1'b1;
            match_n  = '0;
            state_n  = VERIFY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SEARCH; match_cnt <= '0; ref_meas <= '0; locked <= 1'b0;
      hs_q <= 1'b0; vs_q <= 1'b0; bl_q <= 1'b0;
      h_cnt <= '0; v_cnt <= '0;
      hs_acc <= '0; bl_acc <= '0; vs_acc <= '0; va_acc <= '0;
      line_act <= 1'b0; seen <= 1'b0; row <= '0;
      pixel_x <= '0; pixel_y <= '0; frame_start <= 1'b0;
      h_total <= '0; h_sync <= '0; h_active <= '0;
      v_total <= '0; v_sync <= '0; v_active <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      locked    <= (state_n == LOCKED);
      if (load_ref) ref_meas <= meas_n;

      hs_q <= HS; vs_q <= VS; bl_q <= blank_n;
      frame_start <= vs_rise;

      h_cnt    <= hs_rise ? '0 : sat_inc(h_cnt);
      hs_acc   <= hs_rise ? CNT_W'(1) : (HS ? sat_inc(hs_acc) : hs_acc);
      bl_acc   <= hs_rise ? CNT_W'(blank_n) : (blank_n ? sat_inc(bl_acc) : bl_acc);
      line_act <= hs_rise ? blank_n : (line_act | blank_n);

      v_cnt  <= vs_rise ? '0 : (hs_rise ? sat_inc(v_cnt) : v_cnt);
      vs_acc <= vs_rise ? CNT_W'(hs_rise) : ((hs_rise & VS) ? sat_inc(vs_acc) : vs_acc);
      va_acc <= vs_rise ? '0 : ((hs_rise & line_act) ? sat_inc(va_acc) : va_acc);

      seen <= seen | vs_rise;
      row  <= row_n;
      if (pix_ok) begin
        pixel_x <= px_first ? '0 : sat_inc(pixel_x);
        pixel_y <= row_n;
      end

      if (timeout) begin
        h_total <= '0; h_sync <= '0; h_active <= '0;
        v_total <= '0; v_sync <= '0; v_active <= '0;
      end else begin
        h_total <= ht_n; h_sync <= hsy_n; h_active <= ha_n;
        v_total <= vt_n; v_sync <= vsy_n; v_active <= va_n;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  // Leaving LOCKED covers both a mismatching frame and a timeout.
  logic err_inc;
  assign err_inc = (state == LOCKED) & (state_n != LOCKED);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)                            err_count <= '0;
    else if (err_clear)                      err_count <= '0;
    else if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized self-checking bench for vga_sync_decoder
`timescale 1ns/1ps
module tb_vga_sync_decoder;
  localparam int CNT_W       = 11;
  localparam int LOCK_FRAMES = 2;
  localparam int S_SEARCH = 0, S_MEASURE = 1, S_VERIFY = 2, S_LOCKED = 3;

  typedef struct {
    int lt, hsw, ax, aw;   // line total, HS width, first visible column, visible width
    int ft, vsw, ay, ah;   // frame lines, VS lines, first visible line, visible lines
  } timing_t;

  logic vga_clk = 1'b0, reset_n = 1'b0, HS = 1'b0, VS = 1'b0, blank_n = 1'b0;
  logic [CNT_W-1:0] pixel_x, pixel_y, h_total, h_sync, h_active, v_total, v_sync, v_active;
  logic pixel_valid, frame_start, locked;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [15:0] err_count;
  logic        err_clear = 1'b0;
`endif

  vga_sync_decoder #(.LOCK_FRAMES(LOCK_FRAMES), .CNT_W(CNT_W)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .HS(HS), .VS(VS), .blank_n(blank_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .h_total(h_total), .h_sync(h_sync), .h_active(h_active),
    .v_total(v_total), .v_sync(v_sync), .v_active(v_active),
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    .err_count(err_count), .err_clear(err_clear),
`endif
    .locked(locked)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0, errors = 0;
  int mstate, match, err_m, px_e, py_e;
  int ref_m[6];
  bit seen, clr_next;
  timing_t last_t;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = S_SEARCH; match = 0; seen = 0; px_e = 0; py_e = 0; err_m = 0;
    foreach (ref_m[i]) ref_m[i] = 0;
  endtask

  // Frame-level reference: decides the lock state from the timing of the frame just ended.
  task automatic model_vs(input timing_t t, output bit chk);
    int  m[6];
    bit  eq;
    int  prev;
    m = '{t.lt, t.hsw, t.aw, t.ft, t.vsw, t.ah};
    eq = 1;
    foreach (m[i]) if (m[i] != ref_m[i]) eq = 0;
    prev = mstate;
    chk  = (prev != S_SEARCH);
    case (prev)
      S_SEARCH:  mstate = S_MEASURE;
      S_MEASURE: begin ref_m = m; match = 0; mstate = S_VERIFY; end
      S_VERIFY: begin
        if (eq) begin
          match++;
          if (match >= LOCK_FRAMES) mstate = S_LOCKED;
        end else begin
          ref_m = m; match = 0;
        end
      end
      default: if (!eq) begin ref_m = m; match = 0; mstate = S_VERIFY; end
    endcase
    if (prev == S_LOCKED && mstate != S_LOCKED && err_m < 65535) err_m++;
    if (clr_next) err_m = 0;
    seen = 1;
  endtask

  task automatic check_meas(input timing_t t);
    check_val("h_total", h_total, t.lt);
    check_val("h_sync", h_sync, t.hsw);
    check_val("h_active", h_active, t.aw);
    check_val("v_total", v_total, t.ft);
    check_val("v_sync", v_sync, t.vsw);
    check_val("v_active", v_active, t.ah);
  endtask

  task automatic check_all_zero(input string tag);
    timing_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_meas(z);
    check_val({tag, "_pixel_x"}, pixel_x, 0);
    check_val({tag, "_pixel_y"}, pixel_y, 0);
    check_val({tag, "_pixel_valid"}, pixel_valid, 0);
    check_val({tag, "_frame_start"}, frame_start, 0);
    check_val({tag, "_locked"}, locked, 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    check_val({tag, "_err_count"}, err_count, 0);
`endif
  endtask

  task automatic drive_frame(input timing_t t, input int rst_line);
    bit chk, act;
    for (int l = 0; l < t.ft; l++) begin
      for (int c = 0; c < t.lt; c++) begin
        act = (l >= t.ay) && (l < t.ay + t.ah) && (c >= t.ax) && (c < t.ax + t.aw);
        HS = (c < t.hsw); VS = (l < t.vsw); blank_n = act;
        if (l == 0 && c == 0) begin
          model_vs(last_t, chk);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
          err_clear = clr_next;
`endif
        end
        @(posedge vga_clk); #1;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
        err_clear = 1'b0;
`endif
        if (act && seen) begin px_e = c - t.ax; py_e = l - t.ay; end
        check_val("pixel_valid", pixel_valid, int'(act && seen));
        check_val("pixel_x", pixel_x, px_e);
        check_val("pixel_y", pixel_y, py_e);
        if (l == 0 && c == 0) begin
          clr_next = 0;
          check_val("frame_start_hi", frame_start, 1);
          check_val("locked", locked, int'(mstate == S_LOCKED));
          if (chk) check_meas(last_t);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
          check_val("err_count", err_count, err_m);
`endif
        end
        if (l == 0 && c == 1) check_val("frame_start_lo", frame_start, 0);
        if (l == rst_line && c == t.lt / 2) begin
          #1 reset_n = 1'b0;
          #1 check_all_zero("async_rst");
          model_reset();
          reset_n = 1'b1;
        end
      end
    end
    last_t = t;
  endtask

  task automatic drive_lines(input timing_t t, input int n);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < t.lt; c++) begin
        HS = (c < t.hsw); VS = 1'b0; blank_n = 1'b0;
        @(posedge vga_clk); #1;
        check_val("tail_pixel_valid", pixel_valid, 0);
        check_val("tail_pixel_x", pixel_x, px_e);
      end
    end
  endtask

  task automatic idle(input int n);
    HS = 1'b0; VS = 1'b0; blank_n = 1'b0;
    repeat (n) @(posedge vga_clk);
    #1;
    if (mstate == S_LOCKED && err_m < 65535) err_m++;
    mstate = S_SEARCH; match = 0;
    check_val("timeout_locked", locked, 0);
    check_val("timeout_h_total", h_total, 0);
    check_val("timeout_h_sync", h_sync, 0);
    check_val("timeout_h_active", h_active, 0);
    check_val("timeout_v_total", v_total, 0);
    check_val("timeout_v_sync", v_sync, 0);
    check_val("timeout_v_active", v_active, 0);
  endtask

  function automatic timing_t rand_timing();
    timing_t t;
    t.lt  = $urandom_range(48, 30);
    t.hsw = $urandom_range(6, 2);
    t.ax  = t.hsw + $urandom_range(4, 1);
    t.aw  = $urandom_range(t.lt - t.ax - 2, 8);
    t.ft  = $urandom_range(32, 20);
    t.vsw = $urandom_range(3, 1);
    t.ay  = t.vsw + $urandom_range(3, 1);
    t.ah  = $urandom_range(t.ft - t.ay - 2, 5);
    return t;
  endfunction

  initial begin
    timing_t t0, t1, tr;
    t0 = '{40, 4, 6, 24, 30, 2, 4, 20};
    model_reset();
    last_t = t0; clr_next = 0;

    repeat (3) @(posedge vga_clk);
    #1 check_all_zero("reset");
    reset_n = 1'b1;

    repeat (5) drive_frame(t0, -1);
    check_val("nominal_locked", locked, 1);

    t1 = t0; t1.lt = t0.lt + 1;
    repeat (4) drive_frame(t1, -1);
    check_val("changed_h_total", h_total, 41);

    idle(2100);
    drive_lines(t1, 3);
    repeat (5) drive_frame(t1, -1);

    drive_frame(t1, t1.ay + 1);
    repeat (5) drive_frame(t1, -1);

    for (int s = 0; s < 2; s++) begin
      tr = rand_timing();
      repeat (5) drive_frame(tr, -1);
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    begin
      timing_t tx;
      tx = last_t;
      clr_next = 1;
      drive_frame(tx, -1);
      for (int k = 0; k < 4; k++) begin
        tx.lt = (k % 2 == 0) ? tx.lt + 1 : tx.lt - 1;
        drive_frame(tx, -1);
        if (k == 3) clr_next = 1;
        repeat (3) drive_frame(tx, -1);
        if (k == 2) check_val("err_three", err_count, 3);
      end
      check_val("err_cleared", err_count, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
